// File: rtl/key_schedule_seq_pkg.sv
// key_schedule_seq_pkg: shared AES constants, key-size pairs and word helpers for the key expansion engine
package key_schedule_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NK128 = 4;
  localparam int NR128 = 10;
  localparam int NK192 = 6;
  localparam int NR192 = 12;
  localparam int NK256 = 8;
  localparam int NR256 = 14;
  // Forward S-box, entry 0 in the MSBs
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
endpackage

// File: rtl/key_schedule_seq_if.sv
// key_schedule_if: request and round-key stream bundle between key expansion and its consumers
interface key_schedule_if #(parameter int NK = 4, parameter int NR = 10);
  logic start;
  logic [NK*32-1:0] key;
  logic busy;
  logic done;
  logic round_key_valid;
  logic [3:0] round_key_idx;
  logic [127:0] round_key;
  logic [(NR+1)*128-1:0] expansion;
  modport master(output start, key, input busy, done, round_key_valid, round_key_idx, round_key, expansion);
  modport slave(input start, key, output busy, done, round_key_valid, round_key_idx, round_key, expansion);
endinterface

// File: rtl/key_schedule_seq_sub_word.sv
// sub_word: bytewise S-box substitution of a 32-bit word
module sub_word
  import key_schedule_seq_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = {aes_sbox(a[31:24]), aes_sbox(a[23:16]), aes_sbox(a[15:8]), aes_sbox(a[7:0])};
endmodule

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: one AES schedule word per clock, streaming each round key as it completes
module key_schedule_seq
  import key_schedule_seq_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic clk,
  input  logic reset,
  key_schedule_if.slave bus
);
  localparam int TOTAL = 4*(NR+1);
  state_t state, state_n;
  logic [5:0] cnt, phase;
  logic [7:0] rcon;
  logic [NK*32-1:0] win;
  logic [31:0] oldest, newest, sw_in, sw_out, w;
  logic run, accept, last;
  assign run = state == RUN;
  assign accept = bus.start && !run;
  assign last = run && cnt == 6'(TOTAL-1);
  assign phase = cnt % 6'(NK);
  assign oldest = win[NK*32-1 -: 32];
  assign newest = win[31:0];
  assign bus.busy = run;
  assign bus.done = state == DONE;
  assign sw_in = phase == 6'd0 ? rot_word(newest) : newest;
  sub_word u_sub (.a(sw_in), .y(sw_out));
  // The window rotates through the key words first, so oldest is always w[i-NK]
  always_comb begin
    w = cnt < 6'(NK) ? oldest :
        phase == 6'd0 ? oldest ^ sw_out ^ {rcon, 24'h0} :
        (NK == 8 && phase == 6'd4) ? oldest ^ sw_out : oldest ^ newest;
  end
  always_comb begin
    state_n = accept ? RUN : last ? DONE : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      rcon <= 8'h01;
      win <= '0;
      bus.expansion <= '0;
      bus.round_key <= '0;
      bus.round_key_idx <= '0;
      bus.round_key_valid <= 1'b0;
    end else begin
      bus.round_key_valid <= run && cnt[1:0] == 2'd3;
      if (accept) begin
        win <= bus.key;
        cnt <= '0;
        rcon <= 8'h01;
      end else if (run) begin
        win <= {win[NK*32-33:0], w};
        bus.expansion[32*(TOTAL-1-int'(cnt)) +: 32] <= w;
        if (!last) cnt <= cnt + 6'd1;
        if (cnt >= 6'(NK) && phase == 6'd0) rcon <= xtime(rcon);
        if (cnt[1:0] == 2'd3) begin
          bus.round_key <= {win[95:0], w};
          bus.round_key_idx <= cnt[5:2];
        end
      end
    end
  end
endmodule
